// File: rtl/dram_ctrl_pkg.sv
// Shared constants for the DRAM controller: MIG app command encodings and parameter defaults.
package configure;

    localparam logic [2:0] APP_CMD_WR = 3'b000;
    localparam logic [2:0] APP_CMD_RD = 3'b001;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_APP_DATA_WIDTH = 128;
    localparam int unsigned DEF_APP_ADDR_WIDTH = 27;
    localparam int unsigned DEF_LINE_BUF       = 1;
    localparam int unsigned DEF_TIMEOUT        = 1023;

endpackage

// File: rtl/dram_line_buf.sv
// One-line read buffer: tag, line data and valid bit with hit compare, line fill,
// write byte-merge and invalidate.
module dram_line_buf
    import configure::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LINE_WIDTH = DEF_APP_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = 23,
    parameter int unsigned LANE_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush,
    input  logic [TAG_WIDTH-1:0]    i_lookup_tag,
    output logic                    o_hit,
    output logic [LINE_WIDTH-1:0]   o_line,
    input  logic                    i_fill,
    input  logic [TAG_WIDTH-1:0]    i_fill_tag,
    input  logic [LINE_WIDTH-1:0]   i_fill_line,
    input  logic                    i_merge,
    input  logic [TAG_WIDTH-1:0]    i_merge_tag,
    input  logic [LANE_WIDTH-1:0]   i_merge_lane,
    input  logic [DATA_WIDTH-1:0]   i_merge_data,
    input  logic [DATA_WIDTH/8-1:0] i_merge_strb
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    logic                  r_valid;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [LINE_WIDTH-1:0] r_line;
    logic                  w_merge_hit;

    assign o_hit       = r_valid && (r_tag == i_lookup_tag);
    assign o_line      = r_line;
    assign w_merge_hit = i_merge && r_valid && (r_tag == i_merge_tag);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_line  <= '0;
        end else begin
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_line <= i_fill_line;
            end else if (w_merge_hit) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (i_merge_strb[b]) begin
                        r_line[i_merge_lane*DATA_WIDTH + b*8 +: 8] <= i_merge_data[b*8 +: 8];
                    end
                end
            end
            // A flush beats a concurrent fill: the line is captured but never reported valid.
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// CPU-word to Xilinx MIG app-interface bridge with a one-line read buffer and a read-return
// timeout. Single outstanding request, entirely in the MIG ui_clk domain.
module dram_ctrl
    import configure::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned APP_DATA_WIDTH = DEF_APP_DATA_WIDTH,
    parameter int unsigned APP_ADDR_WIDTH = DEF_APP_ADDR_WIDTH,
    parameter int unsigned LINE_BUF       = DEF_LINE_BUF,
    parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        calib_i,
    input  logic                        flush_i,
    input  logic                        mem_valid,
    input  logic [APP_ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]     mem_wstrb,
    output logic                        mem_ready,
    output logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        mem_error,
    output logic [APP_ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                        app_rd_data_valid,
    input  logic                        app_rd_data_end
);

    localparam int unsigned OFF   = $clog2(APP_DATA_WIDTH / 8);
    localparam int unsigned WB    = $clog2(DATA_WIDTH / 8);
    localparam int unsigned LANES = APP_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned TW    = APP_ADDR_WIDTH - OFF;
    localparam int unsigned SW    = DATA_WIDTH / 8;
    localparam int unsigned MW    = APP_DATA_WIDTH / 8;
    localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StResp   = 3'd1;
    localparam logic [2:0] StRdCmd  = 3'd2;
    localparam logic [2:0] StRdWait = 3'd3;
    localparam logic [2:0] StWrData = 3'd4;
    localparam logic [2:0] StWrCmd  = 3'd5;

    function automatic logic [LW-1:0] lane_of(input logic [APP_ADDR_WIDTH-1:0] addr);
        return LW'(addr >> WB) & LW'(LANES - 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_word(input logic [APP_DATA_WIDTH-1:0] line,
                                                        input logic [LW-1:0] lane);
        return line[lane*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [MW-1:0] wr_mask(input logic [LW-1:0] lane,
                                              input logic [SW-1:0] strb);
        logic [MW-1:0] m;
        m = '1;
        m[lane*SW +: SW] = ~strb;
        return m;
    endfunction

    logic [2:0]                r_state, w_state_nxt;
    logic [APP_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [SW-1:0]             r_wstrb;
    logic [CW-1:0]             r_cnt;
    logic                      r_mem_ready, r_mem_error, r_app_en, r_wdf_wren;
    logic [DATA_WIDTH-1:0]     r_mem_rdata;
    logic [2:0]                r_app_cmd;
    logic [APP_ADDR_WIDTH-1:0] r_app_addr;
    logic [APP_DATA_WIDTH-1:0] r_wdf_data;
    logic [MW-1:0]             r_wdf_mask;

    logic                      w_accept, w_is_rd, w_buf_hit, w_hit, w_fill, w_timeout;
    logic [APP_DATA_WIDTH-1:0] w_buf_line;

    assign w_accept  = (r_state == StIdle) && mem_valid && calib_i;
    assign w_is_rd   = (mem_wstrb == '0);
    // A flush in the lookup cycle forces a miss.
    assign w_hit     = (LINE_BUF != 0) && w_buf_hit && !flush_i;
    assign w_fill    = (r_state == StRdWait) && app_rd_data_valid && app_rd_data_end;
    assign w_timeout = (TIMEOUT != 0) && (32'(r_cnt) + 32'd1 >= TIMEOUT);

    dram_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WIDTH (APP_DATA_WIDTH),
        .TAG_WIDTH  (TW),
        .LANE_WIDTH (LW)
    ) u_line_buf (
        .i_clk        (clk_i),
        .i_rst_n      (rst_i),
        .i_flush      (flush_i),
        .i_lookup_tag (mem_addr[APP_ADDR_WIDTH-1:OFF]),
        .o_hit        (w_buf_hit),
        .o_line       (w_buf_line),
        .i_fill       (w_fill && (LINE_BUF != 0)),
        .i_fill_tag   (r_addr[APP_ADDR_WIDTH-1:OFF]),
        .i_fill_line  (app_rd_data),
        .i_merge      ((r_state == StWrCmd) && app_rdy),
        .i_merge_tag  (r_addr[APP_ADDR_WIDTH-1:OFF]),
        .i_merge_lane (lane_of(r_addr)),
        .i_merge_data (r_wdata),
        .i_merge_strb (r_wstrb)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (!w_is_rd)   w_state_nxt = StWrData;
                    else if (w_hit) w_state_nxt = StResp;
                    else            w_state_nxt = StRdCmd;
                end
            end
            StRdCmd:  if (app_rdy) w_state_nxt = StRdWait;
            StRdWait: if (w_fill || w_timeout) w_state_nxt = StResp;
            StWrData: if (app_wdf_rdy) w_state_nxt = StWrCmd;
            StWrCmd:  if (app_rdy) w_state_nxt = StResp;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_cnt       <= '0;
            r_mem_ready <= 1'b0;
            r_mem_error <= 1'b0;
            r_mem_rdata <= '0;
            r_app_en    <= 1'b0;
            r_app_cmd   <= 3'b000;
            r_app_addr  <= '0;
            r_wdf_wren  <= 1'b0;
            r_wdf_data  <= '0;
            r_wdf_mask  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_ready <= 1'b0;
            r_mem_error <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_addr     <= mem_addr;
                        r_wdata    <= mem_wdata;
                        r_wstrb    <= mem_wstrb;
                        r_app_addr <= {mem_addr[APP_ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        if (!w_is_rd) begin
                            r_wdf_wren <= 1'b1;
                            r_wdf_data <= {LANES{mem_wdata}};
                            r_wdf_mask <= wr_mask(lane_of(mem_addr), mem_wstrb);
                        end else if (w_hit) begin
                            r_mem_ready <= 1'b1;
                            r_mem_rdata <= lane_word(w_buf_line, lane_of(mem_addr));
                        end else begin
                            r_app_en  <= 1'b1;
                            r_app_cmd <= APP_CMD_RD;
                        end
                    end
                end
                StRdCmd: begin
                    if (app_rdy) begin
                        r_app_en <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                StRdWait: begin
                    if (w_fill) begin
                        r_mem_ready <= 1'b1;
                        r_mem_rdata <= lane_word(app_rd_data, lane_of(r_addr));
                    end else if (w_timeout) begin
                        r_mem_ready <= 1'b1;
                        r_mem_error <= 1'b1;
                        r_mem_rdata <= '0;
                    end else if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWrData: begin
                    if (app_wdf_rdy) begin
                        r_wdf_wren <= 1'b0;
                        r_app_en   <= 1'b1;
                        r_app_cmd  <= APP_CMD_WR;
                    end
                end
                StWrCmd: begin
                    if (app_rdy) begin
                        r_app_en    <= 1'b0;
                        r_mem_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_ready    = r_mem_ready;
    assign mem_rdata    = r_mem_rdata;
    assign mem_error    = r_mem_error;
    assign app_addr     = r_app_addr;
    assign app_cmd      = r_app_cmd;
    assign app_en       = r_app_en;
    assign app_wdf_data = r_wdf_data;
    assign app_wdf_mask = r_wdf_mask;
    assign app_wdf_wren = r_wdf_wren;
    assign app_wdf_end  = r_wdf_wren;

endmodule
